// File: rtl/coeff_rom_pkg.sv
// Shared constants for the coefficient store: the power-on coefficient table
// and a helper that fits a table entry to an arbitrary row width.
package coeff_rom_pkg;

  localparam int COEFF_MAX_W = 256;

  localparam logic [31:0] DEFAULT_COEFF [8] = '{
    32'h5F5F5F5F, 32'h1A1A1A1A, 32'h2E2E2E2E, 32'hA5A5A5A5,
    32'h123478A2, 32'h9C7B6A88, 32'hAFAFB4C5, 32'h13CF54AF
  };

  // Entry i mod 8, zero-extended, with every bit at or above 'width' cleared.
  function automatic logic [COEFF_MAX_W-1:0] default_row(input int i, input int width);
    logic [COEFF_MAX_W-1:0] v;
    logic [2:0]             idx;
    idx = 3'(i);
    v   = COEFF_MAX_W'(DEFAULT_COEFF[idx]);
    for (int b = 0; b < COEFF_MAX_W; b++) begin
      if (b >= width) v[b] = 1'b0;
    end
    return v;
  endfunction

endpackage

// File: rtl/coeff_pipe_stage.sv
// One read-pipeline register: valid/data/err that advance on en and
// carry zero data and zero err whenever the incoming valid is low.
module coeff_pipe_stage #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_err,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_err
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_err   <= 1'b0;
    end else if (en) begin
      r_valid <= i_valid;
      r_data  <= i_valid ? i_data : '0;
      r_err   <= i_valid & i_err;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_err   = r_err;

endmodule

// File: rtl/coeff_rom_mp.sv
// Multi-port coefficient store: reloadable register array with default
// contents, combinational lookup and a PIPE_STAGES-deep read pipe per port.
module coeff_rom_mp
  import coeff_rom_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 8,
  parameter int ADDR_W      = 4,
  parameter int NUM_PORTS   = 2,
  parameter int PIPE_STAGES = 3
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  input  logic [NUM_PORTS-1:0]        rd_valid_i,
  input  logic [NUM_PORTS*ADDR_W-1:0] rd_addr_i,
  output logic [NUM_PORTS-1:0]        rd_valid_o,
  output logic [NUM_PORTS*DATA_W-1:0] rd_data_o,
  output logic [NUM_PORTS-1:0]        rd_err_o,
  input  logic                        wr_en,
  input  logic [ADDR_W-1:0]           wr_addr,
  input  logic [DATA_W-1:0]           wr_data,
  output logic                        wr_err_o
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              r_wr_err;
  logic              w_wr_ok;
  logic [IDX_W-1:0]  w_wr_idx;

  assign w_wr_ok  = ({1'b0, wr_addr} < DEPTH_A);
  assign w_wr_idx = wr_addr[IDX_W-1:0];

  // Writes ignore en; out-of-range writes only raise the one-cycle error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= DATA_W'(default_row(i, DATA_W));
      r_wr_err <= 1'b0;
    end else begin
      r_wr_err <= wr_en & ~w_wr_ok;
      if (wr_en && w_wr_ok) r_mem[w_wr_idx] <= wr_data;
    end
  end

  assign wr_err_o = r_wr_err;

  // Read handshake: no ready. A request with rd_valid_i=1 is taken on an edge
  // with en=1 and silently dropped otherwise; rd_valid_o qualifies data/err
  // and holds with the rest of the pipe while en=0.
  logic              w_v [NUM_PORTS][PIPE_STAGES+1];
  logic [DATA_W-1:0] w_d [NUM_PORTS][PIPE_STAGES+1];
  logic              w_e [NUM_PORTS][PIPE_STAGES+1];

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [ADDR_W-1:0] w_addr;
    logic              w_ok;
    logic [IDX_W-1:0]  w_idx;

    assign w_addr    = rd_addr_i[p*ADDR_W +: ADDR_W];
    assign w_ok      = ({1'b0, w_addr} < DEPTH_A);
    assign w_idx     = w_addr[IDX_W-1:0];
    assign w_v[p][0] = rd_valid_i[p];
    assign w_d[p][0] = w_ok ? r_mem[w_idx] : '0;
    assign w_e[p][0] = ~w_ok;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
      coeff_pipe_stage #(.DATA_W(DATA_W)) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .i_valid (w_v[p][s]),
        .i_data  (w_d[p][s]),
        .i_err   (w_e[p][s]),
        .o_valid (w_v[p][s+1]),
        .o_data  (w_d[p][s+1]),
        .o_err   (w_e[p][s+1])
      );
    end

    assign rd_valid_o[p]                  = w_v[p][PIPE_STAGES];
    assign rd_data_o[p*DATA_W +: DATA_W]  = w_d[p][PIPE_STAGES];
    assign rd_err_o[p]                    = w_e[p][PIPE_STAGES];
  end

endmodule

// File: tb/tb_coeff_rom_mp.sv
// Directed bench for coeff_rom_mp with default parameters (32b x 8 rows,
// 2 ports, 3 stages). Inputs change and outputs are sampled on negedges.
module tb_coeff_rom_mp;

  localparam int DATA_W      = 32;
  localparam int DEPTH       = 8;
  localparam int ADDR_W      = 4;
  localparam int NUM_PORTS   = 2;
  localparam int PIPE_STAGES = 3;

  logic                        clk = 1'b0;
  logic                        rst_n = 1'b0;
  logic                        en = 1'b0;
  logic [NUM_PORTS-1:0]        rd_valid_i = '0;
  logic [NUM_PORTS*ADDR_W-1:0] rd_addr_i = '0;
  logic [NUM_PORTS-1:0]        rd_valid_o;
  logic [NUM_PORTS*DATA_W-1:0] rd_data_o;
  logic [NUM_PORTS-1:0]        rd_err_o;
  logic                        wr_en = 1'b0;
  logic [ADDR_W-1:0]           wr_addr = '0;
  logic [DATA_W-1:0]           wr_data = '0;
  logic                        wr_err_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_rows [8] = '{
    32'h5F5F5F5F, 32'h1A1A1A1A, 32'h2E2E2E2E, 32'hA5A5A5A5,
    32'h123478A2, 32'h9C7B6A88, 32'hAFAFB4C5, 32'h13CF54AF
  };

  // Clock / reset
  always #5 clk = ~clk;

  coeff_rom_mp #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .NUM_PORTS(NUM_PORTS), .PIPE_STAGES(PIPE_STAGES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .rd_valid_i (rd_valid_i),
    .rd_addr_i  (rd_addr_i),
    .rd_valid_o (rd_valid_o),
    .rd_data_o  (rd_data_o),
    .rd_err_o   (rd_err_o),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err_o   (wr_err_o)
  );

  task automatic idle(input int n);
    rd_valid_i = '0;
    wr_en      = 1'b0;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b00) begin n_err++; $display("FAIL reset_valid got %b want 00", rd_valid_o); end
    n_vec++; if (rd_data_o !== 64'h0) begin n_err++; $display("FAIL reset_data got %h want 0", rd_data_o); end
    n_vec++; if (rd_err_o !== 2'b00) begin n_err++; $display("FAIL reset_err got %b want 00", rd_err_o); end
    n_vec++; if (wr_err_o !== 1'b0) begin n_err++; $display("FAIL reset_wr_err got %b want 0", wr_err_o); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_default_read();
    rd_valid_i = 2'b11;
    rd_addr_i  = {4'd5, 4'd3};
    @(negedge clk);
    rd_valid_i = 2'b00;
    n_vec++; if (rd_valid_o !== 2'b00 || rd_data_o !== 64'h0) begin n_err++; $display("FAIL dflt_edge1 got v=%b d=%h want v=00 d=0", rd_valid_o, rd_data_o); end
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b00 || rd_data_o !== 64'h0) begin n_err++; $display("FAIL dflt_edge2 got v=%b d=%h want v=00 d=0", rd_valid_o, rd_data_o); end
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b11) begin n_err++; $display("FAIL dflt_valid got %b want 11", rd_valid_o); end
    n_vec++; if (rd_data_o[31:0] !== 32'hA5A5A5A5) begin n_err++; $display("FAIL dflt_data0 got %h want A5A5A5A5", rd_data_o[31:0]); end
    n_vec++; if (rd_data_o[63:32] !== 32'h9C7B6A88) begin n_err++; $display("FAIL dflt_data1 got %h want 9C7B6A88", rd_data_o[63:32]); end
    n_vec++; if (rd_err_o !== 2'b00) begin n_err++; $display("FAIL dflt_err got %b want 00", rd_err_o); end
    idle(1);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 11; k++) begin
      rd_valid_i = (k < 8) ? 2'b01 : 2'b00;
      rd_addr_i  = {4'd0, 4'(k)};
      @(negedge clk);
      if (k >= 2 && k < 10) begin
        n_vec++; if (rd_valid_o !== 2'b01 || rd_data_o[31:0] !== exp_rows[k-2]) begin
          n_err++; $display("FAIL b2b_row%0d got v=%b d=%h want v=01 d=%h", k-2, rd_valid_o, rd_data_o[31:0], exp_rows[k-2]);
        end
      end else begin
        n_vec++; if (rd_valid_o !== 2'b00) begin n_err++; $display("FAIL b2b_idle%0d got v=%b want 00", k, rd_valid_o); end
      end
    end
    rd_valid_i = 2'b00;
  endtask

  task automatic test_stall();
    rd_valid_i = 2'b01;
    rd_addr_i  = {4'd0, 4'd1};
    @(negedge clk);
    en         = 1'b0;
    rd_addr_i  = {4'd0, 4'd0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (rd_valid_o !== 2'b00) begin n_err++; $display("FAIL stall_hold%0d got v=%b want 00", i, rd_valid_o); end
    end
    en         = 1'b1;
    rd_valid_i = 2'b00;
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b00) begin n_err++; $display("FAIL stall_edge2 got v=%b want 00", rd_valid_o); end
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b01 || rd_data_o[31:0] !== 32'h1A1A1A1A) begin
      n_err++; $display("FAIL stall_result got v=%b d=%h want v=01 d=1A1A1A1A", rd_valid_o, rd_data_o[31:0]);
    end
    en = 1'b0;
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b01 || rd_data_o[31:0] !== 32'h1A1A1A1A) begin
      n_err++; $display("FAIL stall_out_hold got v=%b d=%h want v=01 d=1A1A1A1A", rd_valid_o, rd_data_o[31:0]);
    end
    en = 1'b1;
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b00 || rd_data_o !== 64'h0) begin
      n_err++; $display("FAIL stall_dropped got v=%b d=%h want v=00 d=0", rd_valid_o, rd_data_o);
    end
  endtask

  task automatic test_write_collision();
    wr_en      = 1'b1;
    wr_addr    = 4'd2;
    wr_data    = 32'hDEADBEEF;
    rd_valid_i = 2'b01;
    rd_addr_i  = {4'd0, 4'd2};
    @(negedge clk);
    wr_en = 1'b0;
    n_vec++; if (wr_err_o !== 1'b0) begin n_err++; $display("FAIL wr_ok_err got %b want 0", wr_err_o); end
    @(negedge clk);
    rd_valid_i = 2'b00;
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b01 || rd_data_o[31:0] !== 32'h2E2E2E2E) begin
      n_err++; $display("FAIL coll_old got v=%b d=%h want v=01 d=2E2E2E2E", rd_valid_o, rd_data_o[31:0]);
    end
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b01 || rd_data_o[31:0] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL coll_new got v=%b d=%h want v=01 d=DEADBEEF", rd_valid_o, rd_data_o[31:0]);
    end
    idle(1);
  endtask

  task automatic test_range();
    rd_valid_i = 2'b11;
    rd_addr_i  = {4'd7, 4'd9};
    wr_en      = 1'b1;
    wr_addr    = 4'd12;
    wr_data    = 32'hFFFFFFFF;
    @(negedge clk);
    wr_en      = 1'b0;
    rd_valid_i = 2'b00;
    n_vec++; if (wr_err_o !== 1'b1) begin n_err++; $display("FAIL wr_err_set got %b want 1", wr_err_o); end
    @(negedge clk);
    n_vec++; if (wr_err_o !== 1'b0) begin n_err++; $display("FAIL wr_err_clear got %b want 0", wr_err_o); end
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b11) begin n_err++; $display("FAIL rng_valid got %b want 11", rd_valid_o); end
    n_vec++; if (rd_err_o !== 2'b01) begin n_err++; $display("FAIL rng_err got %b want 01", rd_err_o); end
    n_vec++; if (rd_data_o[31:0] !== 32'h0) begin n_err++; $display("FAIL rng_data0 got %h want 0", rd_data_o[31:0]); end
    n_vec++; if (rd_data_o[63:32] !== 32'h13CF54AF) begin n_err++; $display("FAIL rng_data1 got %h want 13CF54AF", rd_data_o[63:32]); end
    rd_valid_i = 2'b11;
    rd_addr_i  = {4'd0, 4'd4};
    @(negedge clk);
    rd_valid_i = 2'b00;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (rd_data_o[31:0] !== 32'h123478A2) begin n_err++; $display("FAIL rng_row4_kept got %h want 123478A2", rd_data_o[31:0]); end
    n_vec++; if (rd_data_o[63:32] !== 32'h5F5F5F5F) begin n_err++; $display("FAIL rng_row0_kept got %h want 5F5F5F5F", rd_data_o[63:32]); end
    idle(2);
  endtask

  task automatic test_midflight_reset();
    rd_valid_i = 2'b01;
    rd_addr_i  = {4'd0, 4'd2};
    for (int i = 0; i < 3; i++) @(negedge clk);
    rd_valid_i = 2'b00;
    n_vec++; if (rd_valid_o !== 2'b01 || rd_data_o[31:0] !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL mid_inflight got v=%b d=%h want v=01 d=DEADBEEF", rd_valid_o, rd_data_o[31:0]);
    end
    #1 rst_n = 1'b0;
    #1;
    n_vec++; if (rd_valid_o !== 2'b00 || rd_data_o !== 64'h0) begin
      n_err++; $display("FAIL mid_async_clear got v=%b d=%h want v=00 d=0", rd_valid_o, rd_data_o);
    end
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_vec++; if (rd_valid_o !== 2'b00) begin n_err++; $display("FAIL mid_no_stale%0d got v=%b want 00", i, rd_valid_o); end
    end
    rd_valid_i = 2'b01;
    @(negedge clk);
    rd_valid_i = 2'b00;
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (rd_valid_o !== 2'b01 || rd_data_o[31:0] !== 32'h2E2E2E2E) begin
      n_err++; $display("FAIL mid_row2_default got v=%b d=%h want v=01 d=2E2E2E2E", rd_valid_o, rd_data_o[31:0]);
    end
  endtask

  initial begin
    test_reset();
    test_default_read();
    test_back_to_back();
    test_stall();
    test_write_collision();
    test_range();
    test_midflight_reset();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/coeff_rom_mp.md
Name: coeff_rom_mp

Overview:
- Parametrised multi-port coefficient store; successor to the fixed 32-bit, 8-entry, dual-port ROM in the NN datapath.
- Width, depth, read-port count and pipeline depth are generic. Adds valid tracking, global stall, out-of-range flagging and a write port for reloading coefficients at run time.
- Sits between the layer controller (which issues row addresses) and the MAC array (which consumes coefficient rows).

Parameters:
- DATA_W, 32, coefficient row width in bits.
- DEPTH, 8, number of rows; minimum 2.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= DEPTH.
- NUM_PORTS, 2, number of independent read ports; minimum 1.
- PIPE_STAGES, 3, register stages from request to output; minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- en  in  1  pipeline advance; 0 = stall all read stages.
- rd_valid_i  in  NUM_PORTS  per-port read request.
- rd_addr_i  in  NUM_PORTS*ADDR_W  packed addresses; port p uses bits [p*ADDR_W +: ADDR_W].
- rd_valid_o  out  NUM_PORTS  per-port result valid.
- rd_data_o  out  NUM_PORTS*DATA_W  packed result rows.
- rd_err_o  out  NUM_PORTS  per-port flag: the address was >= DEPTH.
- wr_en  in  1  coefficient write strobe.
- wr_addr  in  ADDR_W  write row.
- wr_data  in  DATA_W  write data.
- wr_err_o  out  1  registered flag: the last wr_en had wr_addr >= DEPTH.

Behaviour:
- Storage is a register array of DEPTH x DATA_W.
- On rst_n low, row i loads DEFAULT_COEFF[i mod 8], truncated or zero-extended to DATA_W. The table is 5F5F5F5F, 1A1A1A1A, 2E2E2E2E, A5A5A5A5, 123478A2, 9C7B6A88, AFAFB4C5, 13CF54AF.
- Reset values of outputs: rd_valid_o, rd_data_o, rd_err_o, wr_err_o and every internal stage register are 0.
- Read lookup is combinational from rd_addr_i and feeds stage 1. Stages 1..PIPE_STAGES are registered. The last stage drives the outputs directly.
- Latency: a request sampled at edge t appears on the outputs after edge t+PIPE_STAGES-1, i.e. exactly PIPE_STAGES edges with en=1.
- Stage load rule, applied only when en=1:
  - valid advances.
  - If the incoming valid is 1: data takes the lookup result, err takes the range check.
  - If the incoming valid is 0: data and err load 0. This guarantees rd_data_o=0 and rd_err_o=0 whenever rd_valid_o=0.
- Out of range (addr >= DEPTH) with valid: data=0, err=1, valid=1. The request still completes.
- en=0: all read stages hold, including outputs. Requests presented during a stall are dropped. The upstream controller must hold them.
- Writes are independent of en.
  - At a rising edge with wr_en=1 and wr_addr < DEPTH, the row is updated.
  - Otherwise no row changes; wr_err_o is set to 1 for one cycle if wr_en=1 with wr_addr >= DEPTH, else 0.
- Read/write collision on the same row in the same cycle: the read captures the old contents. The new value is visible to requests sampled on the following edge.
- Ports are fully independent. Identical addresses on several ports all return the same row.
- Reset mid-operation: all in-flight reads are discarded (valids cleared) and contents revert to defaults. The first valid output after release needs a fresh request plus PIPE_STAGES edges.

Decomposition:
- Package coeff_rom_pkg holds DEFAULT_COEFF (8 x 32-bit constant array) and a function default_row(i, width) returning the masked or extended value.
- One sub-module, coeff_pipe_stage: a single valid/data/err register with en and the zero-on-invalid rule.
  - Top instantiates it NUM_PORTS x PIPE_STAGES via generate.
  - Top owns the storage array, write logic and combinational lookup.

Test Plan:
- Reset default read: after reset, port0 reads addr 3 and port1 reads addr 5 in the same cycle -> exactly 3 edges later, valid=2'b11, data0=A5A5A5A5, data1=9C7B6A88, err=0; the preceding cycles show valid=0 and data=0.
- Back-to-back streaming: port0 issues addrs 0..7 on consecutive cycles -> outputs 5F5F5F5F..13CF54AF on consecutive cycles, with no bubbles after 3 cycles of latency.
- Stall: issue addr 1, drop en for 4 cycles after edge 1, then restore -> 1A1A1A1A appears after 3 enabled edges, and outputs hold steady during the stall.
- Write and collision: write DEADBEEF to row 2 while port0 reads row 2 in the same cycle, then read again -> first result 2E2E2E2E, second DEADBEEF.
- Range errors: read addr 9 with DEPTH=8 -> valid=1, err=1, data=0. Write addr 12 -> wr_err_o=1 for one cycle and no row changes.
- Mid-flight reset: with 3 reads in flight, pulse rst_n low between edges -> valids drop immediately, no stale results emerge, and row 2 reads 2E2E2E2E again.
